// File: rtl/motor_encoder_reader_pkg.sv
// motor_pkg: shared encoder step type, clock constants and quadrature decode
package motor_pkg;
  typedef enum logic [1:0] {STEP_NONE, STEP_FWD, STEP_REV, STEP_ILLEGAL} step_t;
  localparam int unsigned CLK_HZ = 100_000_000;
  localparam int unsigned DEF_WINDOW_CYCLES = CLK_HZ / 100;
  // forward order is 00->10->11->01->00, so the forward successor of p is {~p[0], p[1]}
  function automatic step_t decode_step(input logic [1:0] p, input logic [1:0] s);
    return (p == s) ? STEP_NONE : (&(p ^ s)) ? STEP_ILLEGAL :
           (s == {~p[0], p[1]}) ? STEP_FWD : STEP_REV;
  endfunction
endpackage

// File: rtl/motor_encoder_reader_sync.sv
// encoder_sync: N-stage single-bit synchronizer, sync active-low reset to 0
//   clk, rst_n : clock and synchronous active-low reset
//   d_i        : asynchronous input
//   q_o        : synchronized output
module encoder_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);
  logic [N-1:0] sync_q;
  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= '0;
    else sync_q <= {sync_q[N-2:0], d_i};
  end
  assign q_o = sync_q[N-1];
endmodule

// File: rtl/motor_encoder_reader.sv
// motor_encoder_reader: x4 quadrature decode into position, direction, windowed speed and error
//   clk, rst_n        : clock and synchronous active-low reset
//   enc_a, enc_b      : asynchronous encoder pins
//   clear             : zeroes position, speed window and err
//   position          : signed wrapping step count
//   speed/speed_valid : net steps of last window, pulsed on update
//   direction, err    : last valid step direction, sticky illegal-transition flag
module motor_encoder_reader
  import motor_pkg::*;
#(
  parameter int          SYNC_STAGES   = 2,
  parameter int          POS_W         = 16,
  parameter int          SPD_W         = 16,
  parameter int unsigned WINDOW_CYCLES = DEF_WINDOW_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             clear,
  output logic [POS_W-1:0] position,
  output logic [SPD_W-1:0] speed,
  output logic             speed_valid,
  output logic             direction,
  output logic             err
);
  localparam int CW = $clog2(WINDOW_CYCLES);
  localparam int PW = $clog2(SYNC_STAGES + 2);
  localparam logic [PW-1:0] PRIME = PW'(SYNC_STAGES + 1);
  localparam logic signed [SPD_W-1:0] SMAX = {1'b0, {(SPD_W-1){1'b1}}};
  logic a_s, b_s;
  logic [1:0] s, p_q;
  logic [PW-1:0] prime_q, prime_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic signed [SPD_W-1:0] acc_q, acc_d, acc_step, spd_q, spd_d;
  logic [CW-1:0] win_q, win_d;
  logic vld_q, vld_d, dir_q, dir_d, err_q, err_d;
  logic priming, fwd, rev, last;
  step_t st;
  encoder_sync #(.N(SYNC_STAGES)) u_sync_a (.clk(clk), .rst_n(rst_n), .d_i(enc_a), .q_o(a_s));
  encoder_sync #(.N(SYNC_STAGES)) u_sync_b (.clk(clk), .rst_n(rst_n), .d_i(enc_b), .q_o(b_s));
  // priming lets p settle on the real pin state before any step is trusted
  always_comb begin
    s = {a_s, b_s};
    priming = prime_q != PRIME;
    st = priming ? STEP_NONE : decode_step(p_q, s);
    fwd = st == STEP_FWD;
    rev = st == STEP_REV;
    last = win_q == CW'(WINDOW_CYCLES - 1);
    acc_step = (fwd && acc_q != SMAX) ? acc_q + SPD_W'(1) :
               (rev && acc_q != -SMAX) ? acc_q - SPD_W'(1) : acc_q;
    prime_d = priming ? prime_q + 1'b1 : prime_q;
    pos_d = clear ? '0 : fwd ? pos_q + 1'b1 : rev ? pos_q - 1'b1 : pos_q;
    acc_d = (clear || last) ? '0 : acc_step;
    win_d = (clear || last) ? '0 : win_q + 1'b1;
    vld_d = last && !clear;
    spd_d = vld_d ? acc_step : spd_q;
    dir_d = clear ? dir_q : fwd ? 1'b1 : rev ? 1'b0 : dir_q;
    err_d = !clear && (err_q || st == STEP_ILLEGAL);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_q <= '0;
      prime_q <= '0;
      pos_q <= '0;
      acc_q <= '0;
      spd_q <= '0;
      win_q <= '0;
      vld_q <= 1'b0;
      dir_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      p_q <= s;
      prime_q <= prime_d;
      pos_q <= pos_d;
      acc_q <= acc_d;
      spd_q <= spd_d;
      win_q <= win_d;
      vld_q <= vld_d;
      dir_q <= dir_d;
      err_q <= err_d;
    end
  end
  assign position = pos_q;
  assign speed = spd_q;
  assign speed_valid = vld_q;
  assign direction = dir_q;
  assign err = err_q;
endmodule

// File: tb/tb_motor_encoder_reader.sv
// tb_motor_encoder_reader: directed self-checking bench for motor_encoder_reader
module tb_motor_encoder_reader;
  logic clk = 0, rst_n = 0, rst4_n = 0, enc_a = 0, enc_b = 0, clear = 0;
  logic [15:0] position, speed, speed4;
  logic [3:0] position4;
  logic speed_valid, direction, err, sv4, dir4, err4;
  int checks = 0, passes = 0, idx = 0;
  logic [1:0] seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
  motor_encoder_reader #(.WINDOW_CYCLES(100)) dut (
    .clk(clk), .rst_n(rst_n), .enc_a(enc_a), .enc_b(enc_b), .clear(clear),
    .position(position), .speed(speed), .speed_valid(speed_valid),
    .direction(direction), .err(err)
  );
  motor_encoder_reader #(.POS_W(4), .WINDOW_CYCLES(100)) dut4 (
    .clk(clk), .rst_n(rst4_n), .enc_a(enc_a), .enc_b(enc_b), .clear(1'b0),
    .position(position4), .speed(speed4), .speed_valid(sv4),
    .direction(dir4), .err(err4)
  );
  always #5 clk = ~clk;
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic step(input int d);
    idx = (idx + d + 4) % 4;
    {enc_a, enc_b} = seq[idx];
  endtask
  task automatic do_reset();
    rst_n = 0;
    tick(2);
    rst_n = 1;
  endtask
  task automatic test_reset();
    idx = 0;
    {enc_a, enc_b} = 2'b00;
    do_reset();
    checks++; if (position !== 16'd0) $display("FAIL reset_position got %h exp 0000", position); else passes++;
    checks++; if (speed !== 16'd0) $display("FAIL reset_speed got %h exp 0000", speed); else passes++;
    checks++; if (speed_valid !== 1'b0) $display("FAIL reset_speed_valid got %b exp 0", speed_valid); else passes++;
    checks++; if (direction !== 1'b0) $display("FAIL reset_direction got %b exp 0", direction); else passes++;
    checks++; if (err !== 1'b0) $display("FAIL reset_err got %b exp 0", err); else passes++;
  endtask
  task automatic test_forward();
    tick(5);
    repeat (32) begin step(1); tick(10); end
    checks++; if (position !== 16'd32) $display("FAIL fwd_position got %h exp 0020", position); else passes++;
    checks++; if (direction !== 1'b1) $display("FAIL fwd_direction got %b exp 1", direction); else passes++;
    checks++; if (err !== 1'b0) $display("FAIL fwd_err got %b exp 0", err); else passes++;
  endtask
  task automatic test_reverse();
    clear = 1;
    tick(1);
    clear = 0;
    checks++; if (position !== 16'd0) $display("FAIL rev_clear_position got %h exp 0000", position); else passes++;
    repeat (5) begin step(-1); tick(10); end
    checks++; if (position !== 16'hFFFB) $display("FAIL rev_position got %h exp fffb", position); else passes++;
    checks++; if (direction !== 1'b0) $display("FAIL rev_direction got %b exp 0", direction); else passes++;
    repeat (5) begin step(1); tick(10); end
    checks++; if (position !== 16'd0) $display("FAIL rev_back_position got %h exp 0000", position); else passes++;
    checks++; if (direction !== 1'b1) $display("FAIL rev_back_direction got %b exp 1", direction); else passes++;
  endtask
  task automatic test_illegal();
    idx = 2;
    {enc_a, enc_b} = 2'b11;
    do_reset();
    tick(6);
    checks++; if (err !== 1'b0) $display("FAIL prime_err got %b exp 0", err); else passes++;
    checks++; if (position !== 16'd0) $display("FAIL prime_position got %h exp 0000", position); else passes++;
    idx = 0;
    {enc_a, enc_b} = 2'b00;
    tick(5);
    checks++; if (err !== 1'b1) $display("FAIL illegal_err got %b exp 1", err); else passes++;
    checks++; if (position !== 16'd0) $display("FAIL illegal_position got %h exp 0000", position); else passes++;
    checks++; if (direction !== 1'b0) $display("FAIL illegal_direction got %b exp 0", direction); else passes++;
    clear = 1;
    tick(1);
    clear = 0;
    checks++; if (err !== 1'b0) $display("FAIL illegal_clear_err got %b exp 0", err); else passes++;
  endtask
  task automatic test_speed();
    logic [15:0] exp_spd;
    idx = 0;
    {enc_a, enc_b} = 2'b00;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if (c % 10 == 5) step(c < 300 ? 1 : -1);
      tick(1);
      exp_spd = (c < 300) ? 16'd10 : 16'hFFF6;
      if (c % 100 == 99) begin
        checks++; if (speed_valid !== 1'b1 || speed !== exp_spd)
          $display("FAIL speed_window c=%0d got valid=%b speed=%h exp valid=1 speed=%h", c, speed_valid, speed, exp_spd);
        else passes++;
      end else if (speed_valid) begin
        checks++;
        $display("FAIL speed_spurious_valid c=%0d got valid=1 exp 0", c);
      end
    end
  endtask
  task automatic test_clear_step();
    int e, pulses, first;
    idx = 0;
    {enc_a, enc_b} = 2'b00;
    do_reset();
    tick(10);
    step(1);
    tick(2);
    clear = 1;
    tick(1);
    clear = 0;
    checks++; if (position !== 16'd0) $display("FAIL clrstep_position got %h exp 0000", position); else passes++;
    checks++; if (direction !== 1'b0) $display("FAIL clrstep_direction got %b exp 0", direction); else passes++;
    e = 13;
    pulses = 0;
    first = 0;
    while (e < 130) begin
      if (e == 20) step(1);
      tick(1);
      e++;
      if (speed_valid) begin
        pulses++;
        if (first == 0) first = e;
      end
    end
    checks++; if (first !== 113) $display("FAIL clrstep_first_valid got edge %0d exp 113", first); else passes++;
    checks++; if (pulses !== 1) $display("FAIL clrstep_pulses got %0d exp 1", pulses); else passes++;
    checks++; if (speed !== 16'd1) $display("FAIL clrstep_speed got %h exp 0001", speed); else passes++;
    checks++; if (position !== 16'd1) $display("FAIL clrstep_after_position got %h exp 0001", position); else passes++;
    checks++; if (direction !== 1'b1) $display("FAIL clrstep_after_direction got %b exp 1", direction); else passes++;
  endtask
  task automatic test_wrap();
    rst4_n = 1;
    tick(5);
    repeat (7) begin step(1); tick(5); end
    checks++; if (position4 !== 4'h7) $display("FAIL wrap_preload got %h exp 7", position4); else passes++;
    step(1);
    tick(5);
    checks++; if (position4 !== 4'h8) $display("FAIL wrap_over got %h exp 8", position4); else passes++;
    step(-1);
    tick(5);
    checks++; if (position4 !== 4'h7) $display("FAIL wrap_back got %h exp 7", position4); else passes++;
  endtask
  initial begin
    test_reset();
    test_forward();
    test_reverse();
    test_illegal();
    test_speed();
    test_clear_step();
    test_wrap();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
